// File: rtl/hsid_x_ctrl_mc_pkg.sv
// Register map, STATUS bit positions and channel FSM states for hsid_x_ctrl_reg_mc.
package hsid_x_ctrl_mc_pkg;

  typedef enum logic [3:0] {
    REG_STATUS              = 4'd0,
    REG_LIBRARY_SIZE        = 4'd1,
    REG_PIXEL_BANDS         = 4'd2,
    REG_CAPTURED_PIXEL_ADDR = 4'd3,
    REG_LIBRARY_PIXEL_ADDR  = 4'd4,
    REG_MSE_MIN_REF         = 4'd5,
    REG_MSE_MIN_VALUE       = 4'd6,
    REG_MSE_MAX_REF         = 4'd7,
    REG_MSE_MAX_VALUE       = 4'd8
  } reg_off_e;

  localparam int ST_START   = 0;
  localparam int ST_IDLE    = 1;
  localparam int ST_READY   = 2;
  localparam int ST_DONE    = 3;
  localparam int ST_CLEAR   = 4;
  localparam int ST_ERR     = 5;
  localparam int ST_PENDING = 6;
  localparam int ST_BUSY    = 7;

  localparam logic [31:0] CH_STRIDE = 32'h40;
  localparam logic [31:0] IRQ_BASE  = 32'h400;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_ARMED = 2'd1,
    CH_RUN   = 2'd2
  } ch_state_e;

endpackage

// File: rtl/hsid_x_reg_pkg.sv
// Register-bus request/response types shared by HSID-X register blocks.
package hsid_x_reg_pkg;

  localparam int REG_AW = 32;
  localparam int REG_DW = 32;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] wdata;
  } reg_req_t;

  typedef struct packed {
    logic              ready;
    logic [REG_DW-1:0] rdata;
    logic              error;
  } reg_rsp_t;

endpackage

// File: rtl/hsid_x_ctrl_ch.sv
// One HSID-X channel: shadow/launched config, captured results, launch FSM.
//   state    | meaning
//   CH_IDLE  | no job requested
//   CH_ARMED | start requested, waiting for core idle&ready
//   CH_RUN   | job launched, waiting for done/error rising edge
module hsid_x_ctrl_ch
  import hsid_x_ctrl_mc_pkg::*;
#(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 9,
  parameter int HSP_LIBRARY_WIDTH = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [3:0]                   word,
  input  logic [WORD_WIDTH-1:0]        wdata,
  output logic [WORD_WIDTH-1:0]        rd_data,
  input  logic                         idle,
  input  logic                         ready,
  input  logic                         done,
  input  logic                         error,
  input  logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref,
  input  logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref,
  input  logic [WORD_WIDTH-1:0]        mse_min_value,
  input  logic [WORD_WIDTH-1:0]        mse_max_value,
  output logic                         start,
  output logic                         clear,
  output logic [HSP_LIBRARY_WIDTH-1:0] library_size,
  output logic [HSP_BANDS_WIDTH-1:0]   pixel_bands,
  output logic [WORD_WIDTH-1:0]        captured_pixel_addr,
  output logic [WORD_WIDTH-1:0]        library_pixel_addr,
  output logic                         done_flag,
  output logic                         err_flag
);

  ch_state_e state, state_n;
  logic pending, pending_n, done_n, err_n, start_n, clear_n;
  logic launch, capture;
  logic done_q, done_q2, err_q, err_q2;
  logic done_rise, err_rise, wr_status, wr_start, wr_clear;

  logic [HSP_LIBRARY_WIDTH-1:0] lib_sh, min_ref_r, max_ref_r;
  logic [HSP_BANDS_WIDTH-1:0]   bands_sh;
  logic [WORD_WIDTH-1:0]        cap_sh, libaddr_sh, min_val_r, max_val_r;
  logic [7:0]                   status_byte;

  // Edges are taken between two registered samples so the core inputs are synchronised first.
  assign done_rise = done_q & ~done_q2;
  assign err_rise  = err_q & ~err_q2;
  assign wr_status = wr_en && (word == 4'(REG_STATUS));
  assign wr_start  = wr_status & wdata[ST_START];
  assign wr_clear  = wr_status & wdata[ST_CLEAR];

  always_comb begin
    state_n   = state;
    pending_n = pending;
    done_n    = done_flag;
    err_n     = err_flag;
    start_n   = 1'b0;
    clear_n   = 1'b0;
    launch    = 1'b0;
    capture   = 1'b0;
    if (wr_status && wdata[ST_DONE]) done_n = 1'b0;
    if (wr_status && wdata[ST_ERR])  err_n  = 1'b0;
    case (state)
      CH_ARMED: begin
        if (idle && ready) begin
          launch  = 1'b1;
          start_n = 1'b1;
          state_n = CH_RUN;
        end
      end
      CH_RUN: begin
        if (done_rise || err_rise) begin
          capture = 1'b1;
          if (done_rise) done_n = 1'b1;
          if (err_rise)  err_n  = 1'b1;
          if (pending) begin
            state_n   = CH_ARMED;
            pending_n = 1'b0;
          end else begin
            state_n = CH_IDLE;
          end
        end
      end
      default: ;
    endcase
    if (wr_clear) begin
      clear_n   = 1'b1;
      launch    = 1'b0;
      start_n   = 1'b0;
      state_n   = CH_IDLE;
      pending_n = 1'b0;
      done_n    = 1'b0;
      err_n     = 1'b0;
    end
    // A start that coincides with a clear re-arms the freshly cleared channel.
    if (wr_start) begin
      if (state_n == CH_IDLE)          state_n   = CH_ARMED;
      else if (!pending || wr_clear)   pending_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CH_IDLE;
      pending   <= 1'b0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
      start     <= 1'b0;
      clear     <= 1'b0;
      done_q    <= 1'b0;
      done_q2   <= 1'b0;
      err_q     <= 1'b0;
      err_q2    <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      done_flag <= done_n;
      err_flag  <= err_n;
      start     <= start_n;
      clear     <= clear_n;
      done_q    <= done;
      done_q2   <= done_q;
      err_q     <= error;
      err_q2    <= err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lib_sh     <= '0;
      bands_sh   <= '0;
      cap_sh     <= '0;
      libaddr_sh <= '0;
    end else if (wr_en) begin
      case (word)
        4'(REG_LIBRARY_SIZE):        lib_sh     <= wdata[HSP_LIBRARY_WIDTH-1:0];
        4'(REG_PIXEL_BANDS):         bands_sh   <= wdata[HSP_BANDS_WIDTH-1:0];
        4'(REG_CAPTURED_PIXEL_ADDR): cap_sh     <= wdata;
        4'(REG_LIBRARY_PIXEL_ADDR):  libaddr_sh <= wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      library_size        <= '0;
      pixel_bands         <= '0;
      captured_pixel_addr <= '0;
      library_pixel_addr  <= '0;
    end else if (launch) begin
      library_size        <= lib_sh;
      pixel_bands         <= bands_sh;
      captured_pixel_addr <= cap_sh;
      library_pixel_addr  <= libaddr_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_ref_r <= '0;
      max_ref_r <= '0;
      min_val_r <= '0;
      max_val_r <= '0;
    end else if (capture) begin
      min_ref_r <= mse_min_ref;
      max_ref_r <= mse_max_ref;
      min_val_r <= mse_min_value;
      max_val_r <= mse_max_value;
    end
  end

  always_comb begin
    status_byte              = '0;
    status_byte[ST_IDLE]     = idle;
    status_byte[ST_READY]    = ready;
    status_byte[ST_DONE]     = done_flag;
    status_byte[ST_ERR]      = err_flag;
    status_byte[ST_PENDING]  = pending;
    status_byte[ST_BUSY]     = (state != CH_IDLE);
  end

  always_comb begin
    rd_data = '0;
    case (word)
      4'(REG_STATUS):              rd_data = WORD_WIDTH'(status_byte);
      4'(REG_LIBRARY_SIZE):        rd_data = WORD_WIDTH'(lib_sh);
      4'(REG_PIXEL_BANDS):         rd_data = WORD_WIDTH'(bands_sh);
      4'(REG_CAPTURED_PIXEL_ADDR): rd_data = cap_sh;
      4'(REG_LIBRARY_PIXEL_ADDR):  rd_data = libaddr_sh;
      4'(REG_MSE_MIN_REF):         rd_data = WORD_WIDTH'(min_ref_r);
      4'(REG_MSE_MIN_VALUE):       rd_data = min_val_r;
      4'(REG_MSE_MAX_REF):         rd_data = WORD_WIDTH'(max_ref_r);
      4'(REG_MSE_MAX_VALUE):       rd_data = max_val_r;
      default: ;
    endcase
  end

endmodule

// File: rtl/hsid_x_ctrl_reg_mc.sv
// Multi-channel HSID-X control/status register block: decode, read mux, IRQ.
// Optional interrupt aggregation is built when HSID_X_CTRL_IRQ_EN is defined.
module hsid_x_ctrl_reg_mc
  import hsid_x_ctrl_mc_pkg::*;
  import hsid_x_reg_pkg::*;
#(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 9,
  parameter int HSP_LIBRARY_WIDTH = 13,
  parameter int N_CH              = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  reg_req_t                                reg_req,
  output reg_rsp_t                                reg_rsp,
  output logic [N_CH-1:0]                         start,
  output logic [N_CH-1:0]                         clear,
  input  logic [N_CH-1:0]                         idle,
  input  logic [N_CH-1:0]                         ready,
  input  logic [N_CH-1:0]                         done,
  input  logic [N_CH-1:0]                         error,
  output logic [N_CH-1:0][HSP_LIBRARY_WIDTH-1:0]  library_size,
  output logic [N_CH-1:0][HSP_BANDS_WIDTH-1:0]    pixel_bands,
  output logic [N_CH-1:0][WORD_WIDTH-1:0]         captured_pixel_addr,
  output logic [N_CH-1:0][WORD_WIDTH-1:0]         library_pixel_addr,
  input  logic [N_CH-1:0][HSP_LIBRARY_WIDTH-1:0]  mse_min_ref,
  input  logic [N_CH-1:0][HSP_LIBRARY_WIDTH-1:0]  mse_max_ref,
  input  logic [N_CH-1:0][WORD_WIDTH-1:0]         mse_min_value,
  input  logic [N_CH-1:0][WORD_WIDTH-1:0]         mse_max_value,
  output logic                                    irq
);

  logic [3:0]                    ch_idx, word;
  logic                          wr, ch_hit, irq_status_hit, irq_enable_hit;
  logic [N_CH-1:0]               ch_wr, done_flag, err_flag;
  logic [N_CH-1:0][WORD_WIDTH-1:0] ch_rdata;
  logic [WORD_WIDTH-1:0]         ch_sel, irq_status_rd, irq_enable_rd, rdata;
  logic                          rd_err;

  assign ch_idx = reg_req.addr[9:6];
  assign word   = reg_req.addr[5:2];
  assign wr     = reg_req.valid & reg_req.write;

  assign ch_hit = (reg_req.addr[31:11] == '0) && !reg_req.addr[10] &&
                  (reg_req.addr[1:0] == 2'b00) && (word <= 4'(REG_MSE_MAX_VALUE)) &&
                  (int'(ch_idx) < N_CH);
  assign irq_status_hit = (reg_req.addr == IRQ_BASE);
  assign irq_enable_hit = (reg_req.addr == IRQ_BASE + 32'h4);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign ch_wr[c] = wr && ch_hit && (ch_idx == 4'(c));

    hsid_x_ctrl_ch #(
      .WORD_WIDTH        (WORD_WIDTH),
      .HSP_BANDS_WIDTH   (HSP_BANDS_WIDTH),
      .HSP_LIBRARY_WIDTH (HSP_LIBRARY_WIDTH)
    ) u_ch (
      .clk                 (clk),
      .rst                 (rst),
      .wr_en               (ch_wr[c]),
      .word                (word),
      .wdata               (WORD_WIDTH'(reg_req.wdata)),
      .rd_data             (ch_rdata[c]),
      .idle                (idle[c]),
      .ready               (ready[c]),
      .done                (done[c]),
      .error               (error[c]),
      .mse_min_ref         (mse_min_ref[c]),
      .mse_max_ref         (mse_max_ref[c]),
      .mse_min_value       (mse_min_value[c]),
      .mse_max_value       (mse_max_value[c]),
      .start               (start[c]),
      .clear               (clear[c]),
      .library_size        (library_size[c]),
      .pixel_bands         (pixel_bands[c]),
      .captured_pixel_addr (captured_pixel_addr[c]),
      .library_pixel_addr  (library_pixel_addr[c]),
      .done_flag           (done_flag[c]),
      .err_flag            (err_flag[c])
    );
  end

  always_comb begin
    ch_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_idx == 4'(c)) ch_sel = ch_rdata[c];
    end
  end

`ifdef HSID_X_CTRL_IRQ_EN
  logic [N_CH-1:0] irq_enable_q, irq_status;
  logic            irq_q;

  assign irq_status = done_flag | err_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_enable_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      if (wr && irq_enable_hit) irq_enable_q <= reg_req.wdata[N_CH-1:0];
      irq_q <= |(irq_status & irq_enable_q);
    end
  end

  assign irq           = irq_q;
  assign irq_status_rd = WORD_WIDTH'(irq_status);
  assign irq_enable_rd = WORD_WIDTH'(irq_enable_q);
`else
  // Without the aggregator the IRQ registers still decode, reading 0 without a bus error.
  logic unused_irq_src;
  assign unused_irq_src = ^{done_flag, err_flag};
  assign irq            = 1'b0;
  assign irq_status_rd  = '0;
  assign irq_enable_rd  = '0;
`endif

  always_comb begin
    rdata  = '0;
    rd_err = 1'b0;
    if (ch_hit)              rdata  = ch_sel;
    else if (irq_status_hit) rdata  = irq_status_rd;
    else if (irq_enable_hit) rdata  = irq_enable_rd;
    else                     rd_err = reg_req.valid;
  end

  assign reg_rsp.ready = 1'b1;
  assign reg_rsp.rdata = REG_DW'(rdata);
  assign reg_rsp.error = rd_err;

endmodule
